// File: rtl/queue_write_arbiter.sv
// -----------------------------------------------------------------------------
// queue_write_arbiter
//
// Round-robin arbiter that shares one bisynchronous queue write port among
// p_num_reqs val/rdy producers living in the write-clock domain. A winner is
// granted for a burst of up to p_max_burst messages, then priority rotates to
// the requester after it. The datapath is a pure combinational pass-through.
//
// Ports
//   clk      in   1                        queue write clock
//   reset_n  in   1                        asynchronous active-low reset
//   in_val   in   p_num_reqs               per-requester valid
//   in_rdy   out  p_num_reqs               per-requester ready
//   in_msg   in   p_num_reqs*p_data_width  requester i at bits [i*W +: W]
//   out_val  out  1                        to queue w_val
//   out_rdy  in   1                        from queue w_rdy
//   out_msg  out  p_data_width             to queue w_msg
//   out_src  out  clog2(p_num_reqs)        index of the granted requester
// -----------------------------------------------------------------------------
module queue_write_arbiter #(
  parameter int p_data_width = 32,
  parameter int p_num_reqs   = 4,
  parameter int p_max_burst  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [p_num_reqs-1:0]                in_val,
  output logic [p_num_reqs-1:0]                in_rdy,
  input  logic [p_num_reqs*p_data_width-1:0]   in_msg,
  output logic                                 out_val,
  input  logic                                 out_rdy,
  output logic [p_data_width-1:0]              out_msg,
  output logic [$clog2(p_num_reqs)-1:0]        out_src
);

  localparam int c_src_w = $clog2(p_num_reqs);
  localparam int c_cnt_w = $clog2(p_max_burst + 1);

  localparam logic [c_src_w-1:0] c_last_idx = c_src_w'(p_num_reqs - 1);
  localparam logic [c_src_w-1:0] c_src_one  = c_src_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_burst    = c_cnt_w'(p_max_burst);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [c_src_w-1:0]   prio_q,  prio_d;
  logic [c_src_w-1:0]   owner_q, owner_d;
  logic [c_cnt_w-1:0]   cnt_q,   cnt_d;

  logic                 found_s;
  logic [c_src_w-1:0]   grant_s;
  logic [c_src_w-1:0]   sel_s;
  logic                 val_s;
  logic                 rdy_en_s;
  logic [p_data_width-1:0] msg_s;
  logic [c_cnt_w-1:0]   cnt_inc_s;

  // Successor index modulo p_num_reqs (works for non-power-of-2 counts).
  function automatic logic [c_src_w-1:0] next_idx(input logic [c_src_w-1:0] idx);
    logic [c_src_w-1:0] res;
    if (idx == c_last_idx) begin
      res = '0;
    end else begin
      res = idx + c_src_one;
    end
    return res;
  endfunction

  // Round-robin search: first valid requester starting at prio_q, wrapping.
  always_comb begin : search_p
    logic [c_src_w-1:0] idx_v;
    logic               hit_v;
    found_s = 1'b0;
    grant_s = '0;
    idx_v   = prio_q;
    hit_v   = 1'b0;
    for (int k = 0; k < p_num_reqs; k++) begin
      hit_v   = !found_s && in_val[idx_v];
      grant_s = hit_v ? idx_v : grant_s;
      found_s = found_s || hit_v;
      idx_v   = next_idx(idx_v);
    end
  end

  assign cnt_inc_s = cnt_q + c_cnt_one;

  // Next-state logic and grant selection for the IDLE/LOCKED machine.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    sel_s    = '0;
    val_s    = 1'b0;
    rdy_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_s    = grant_s;
        val_s    = found_s;
        rdy_en_s = found_s;
        if (found_s) begin
          // Any offered message locks the grant: a stall must pin the output,
          // and a multi-message burst continues in LOCKED.
          if (out_rdy && (p_max_burst == 1)) begin
            prio_d = next_idx(grant_s);
          end else if (out_rdy) begin
            state_d = ST_LOCKED;
            owner_d = grant_s;
            cnt_d   = c_cnt_one;
          end else begin
            state_d = ST_LOCKED;
            owner_d = grant_s;
            cnt_d   = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        sel_s    = owner_q;
        val_s    = in_val[owner_q];
        rdy_en_s = 1'b1;
        if (!in_val[owner_q] || (out_rdy && (cnt_inc_s == c_burst))) begin
          // Release: owner went idle (one bubble) or burst exhausted.
          state_d = ST_IDLE;
          prio_d  = next_idx(owner_q);
          cnt_d   = '0;
        end else if (out_rdy) begin
          cnt_d = cnt_inc_s;
        end else begin
          // Stalls do not count toward the burst.
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        prio_d  = '0;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Message mux for the selected requester.
  always_comb begin
    msg_s = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      msg_s = (sel_s == c_src_w'(i)) ? in_msg[i*p_data_width +: p_data_width] : msg_s;
    end
  end

  // Outputs are forced to zero combinationally while reset_n is low so the
  // queue sees nothing the instant reset asserts, not at the next edge.
  always_comb begin
    out_val = reset_n & val_s;
    out_src = reset_n ? sel_s : '0;
    out_msg = reset_n ? msg_s : '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      in_rdy[i] = reset_n & rdy_en_s & out_rdy & (sel_s == c_src_w'(i));
    end
  end

  // State, priority pointer, owner and burst counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      prio_q  <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_queue_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_queue_write_arbiter
//
// Directed bench for queue_write_arbiter (N=4, burst=4, W=32). Inputs change
// on the falling edge; outputs are sampled 1 time unit later, well before the
// next rising edge. Each producer's message is {8'hA0+i, 8'h00, seq[i]} where
// seq[i] advances after each accepted transfer, so a held message under stall
// is visible as an unchanged out_msg.
// -----------------------------------------------------------------------------
module tb_queue_write_arbiter;

  logic         clk;
  logic         reset_n;
  logic [3:0]   in_val;
  logic [3:0]   in_rdy;
  logic [127:0] in_msg;
  logic         out_val;
  logic         out_rdy;
  logic [31:0]  out_msg;
  logic [1:0]   out_src;

  int checks;
  int failures;
  int seq [4];

  queue_write_arbiter #(
    .p_data_width (32),
    .p_num_reqs   (4),
    .p_max_burst  (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_src (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] msg_of(input int i);
    logic [7:0] hi;
    hi = 8'hA0 + 8'(i);
    return {hi, 8'h00, 16'(seq[i])};
  endfunction

  task automatic set_msgs();
    for (int i = 0; i < 4; i++) begin
      in_msg[i*32 +: 32] = msg_of(i);
    end
  endtask

  // One clock cycle: drive messages, check outputs, advance producers.
  task automatic step(input string tag, input logic exp_val, input int exp_src,
                      input logic [3:0] exp_rdy);
    logic [3:0] xfer;
    set_msgs();
    #1;
    check_eq({tag, "_val"}, 64'(out_val), 64'(exp_val));
    check_eq({tag, "_rdy"}, 64'(in_rdy), 64'(exp_rdy));
    if (exp_val) begin
      check_eq({tag, "_src"}, 64'(out_src), 64'(exp_src));
      check_eq({tag, "_msg"}, 64'(out_msg), 64'(msg_of(exp_src)));
    end
    xfer = in_rdy & in_val;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (xfer[i]) seq[i] = seq[i] + 1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held_msg;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) seq[i] = 0;
    reset_n = 1'b0;
    in_val  = 4'hF;
    out_rdy = 1'b1;
    in_msg  = '0;
    set_msgs();

    // Reset with every requester valid: nothing offered, nothing accepted.
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_val", 64'(out_val), 64'd0);
    check_eq("rst_rdy", 64'(in_rdy), 64'd0);
    check_eq("rst_src", 64'(out_src), 64'd0);
    check_eq("rst_msg", 64'(out_msg), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Rotation: 0x4, 1x4, 2x4, 3x4, then wrap to 0, no bubbles.
    for (int k = 0; k < 17; k++) begin
      int s;
      s = (k < 16) ? (k / 4) : 0;
      step($sformatf("rot%0d", k), 1'b1, s, 4'(1 << s));
    end
    // Owner 0 drops val while locked: bubble, in_rdy[0] still follows out_rdy.
    in_val = 4'b0000;
    step("rot_drop", 1'b0, 0, 4'b0001);

    // Lone requester 2: ten back-to-back transfers across burst boundaries.
    in_val = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      step($sformatf("lone%0d", k), 1'b1, 2, 4'b0100);
    end
    in_val = 4'b0000;
    step("lone_drop", 1'b0, 0, 4'b0100);

    // Stall: req1 offered while queue full, req0 arrives mid-stall.
    in_val  = 4'b0010;
    out_rdy = 1'b0;
    set_msgs();
    #1;
    held_msg = out_msg;
    @(negedge clk);
    step("stall0", 1'b1, 1, 4'b0000);
    in_val = 4'b0011;
    step("stall1", 1'b1, 1, 4'b0000);
    #1;
    check_eq("stall_hold_msg", 64'(out_msg), 64'(held_msg));
    @(negedge clk);
    out_rdy = 1'b1;
    // Stall cycles did not count: req1 still gets a full burst of four.
    for (int k = 0; k < 4; k++) begin
      step($sformatf("stall_go%0d", k), 1'b1, 1, 4'b0010);
    end
    in_val = 4'b0000;
    step("stall_idle", 1'b0, 0, 4'b0000);

    // Async reset mid-burst of req2 (priority currently points at 2).
    in_val = 4'b0100;
    step("ar0", 1'b1, 2, 4'b0100);
    set_msgs();
    #1;
    check_eq("ar1_val", 64'(out_val), 64'd1);
    check_eq("ar1_src", 64'(out_src), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_val", 64'(out_val), 64'd0);
    check_eq("ar_rdy", 64'(in_rdy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Early release after reset (prio=0): req0 sends 2, drops, req3 follows.
    in_val = 4'b1001;
    step("er0", 1'b1, 0, 4'b0001);
    step("er1", 1'b1, 0, 4'b0001);
    in_val = 4'b1000;
    step("er_bubble", 1'b0, 0, 4'b0001);
    step("er3", 1'b1, 3, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
